// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner, in-order imem requester and instruction buffer feeding decode, with redirect/flush.
// Optional perf counters (o_fetch_cnt, o_stall_cnt) when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_imem_req_valid,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_req_ready,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_id_valid,
  output logic [31:0] o_id_inst,
  output logic [31:0] o_id_pc,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt,
  input  logic        i_id_ready
`else
  input  logic        i_id_ready
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
  state_t r_state;
  logic [31:0] r_pc, r_rsp_pc;
  logic [AW:0] r_inflight, r_drop_cnt, r_count;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [31:0] r_inst_mem [FIFO_DEPTH];
  logic [31:0] r_pc_mem [FIFO_DEPTH];
  logic w_active, w_redir, w_rsp, w_keep, w_pop, w_accept;
  logic [AW+1:0] w_occ;
  logic [AW:0] w_inflight_nxt, w_drop_nxt;
  logic [31:0] w_redir_pc;
  assign w_active   = r_state != IDLE;
  assign w_redir    = w_active & i_redirect_valid;
  assign w_redir_pc = i_redirect_pc & ~32'h3;
  // responses with nothing outstanding (or before start) are spurious and ignored
  assign w_rsp  = w_active & i_imem_rsp_valid & (r_inflight != '0);
  assign w_keep = w_rsp & (r_drop_cnt == '0) & ~w_redir;
  // credit: outstanding requests plus buffered words never exceed the buffer size
  assign w_occ = {1'b0, r_inflight} + {1'b0, r_count};
  assign o_imem_req_valid = (r_state == FETCH) & (w_occ < (AW+2)'(FIFO_DEPTH)) & ~i_redirect_valid;
  assign o_imem_req_addr  = r_pc;
  assign w_accept = o_imem_req_valid & i_imem_req_ready;
  assign o_id_valid = r_count != '0;
  assign o_id_inst  = o_id_valid ? r_inst_mem[r_rd_ptr] : '0;
  assign o_id_pc    = o_id_valid ? r_pc_mem[r_rd_ptr] : '0;
  assign w_pop = o_id_valid & i_id_ready & ~w_redir;
  assign w_inflight_nxt = r_inflight + (AW+1)'(w_accept) - (AW+1)'(w_rsp);
  // on redirect everything still outstanding is stale and must be dropped
  assign w_drop_nxt = w_redir ? w_inflight_nxt
                              : r_drop_cnt - (AW+1)'(w_rsp && (r_drop_cnt != '0));
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state    <= (r_state == IDLE) ? (i_start ? FETCH : IDLE)
                                      : ((w_drop_nxt != '0) ? FLUSH : FETCH);
      r_inflight <= w_inflight_nxt;
      r_drop_cnt <= w_drop_nxt;
      r_pc       <= w_redir ? w_redir_pc : (w_accept ? r_pc + 32'd4 : r_pc);
      r_rsp_pc   <= w_redir ? w_redir_pc : (w_keep ? r_rsp_pc + 32'd4 : r_rsp_pc);
      if (w_redir) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_count  <= r_count + (AW+1)'(w_keep) - (AW+1)'(w_pop);
        r_wr_ptr <= r_wr_ptr + AW'(w_keep);
        r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_keep) begin
      r_inst_mem[r_wr_ptr] <= i_imem_rsp_data;
      r_pc_mem[r_wr_ptr]   <= r_rsp_pc;
    end
  end
`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt, r_stall_cnt;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_fetch_cnt <= r_fetch_cnt + 32'(w_pop);
      r_stall_cnt <= r_stall_cnt + 32'(w_active & i_id_ready & ~o_id_valid);
    end
  end
  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed table plus hand sequences for stream, back-pressure, redirect, wrap and reset.
module tb_if_fetch_unit;
  logic i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0;
  logic o_imem_req_valid, i_imem_req_ready = 1'b0, i_imem_rsp_valid = 1'b0;
  logic [31:0] o_imem_req_addr, i_imem_rsp_data = '0, i_redirect_pc = '0, o_id_inst, o_id_pc;
  logic i_redirect_valid = 1'b0, o_id_valid, i_id_ready = 1'b0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] o_fetch_cnt, o_stall_cnt;
`endif
  if_fetch_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .o_imem_req_valid(o_imem_req_valid), .o_imem_req_addr(o_imem_req_addr),
    .i_imem_req_ready(i_imem_req_ready), .i_imem_rsp_valid(i_imem_rsp_valid),
    .i_imem_rsp_data(i_imem_rsp_data), .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc(i_redirect_pc), .o_id_valid(o_id_valid), .o_id_inst(o_id_inst),
    .o_id_pc(o_id_pc),
`ifdef IF_PERF_CNT_EN
    .o_fetch_cnt(o_fetch_cnt), .o_stall_cnt(o_stall_cnt),
`endif
    .i_id_ready(i_id_ready)
  );
  always #5 i_clk = ~i_clk;
  typedef struct {int due; logic [31:0] data;} rsp_t;
  typedef struct {
    logic start, id_ready, redir; logic [31:0] redir_pc;
    logic e_req_v; logic [31:0] e_req_a; logic e_id_v; logic [31:0] e_inst, e_pc;
  } vec_t;
  rsp_t q[$];
  logic [31:0] acc_q[$];
  int cyc_n = 0, lat = 1, checks = 0, failures = 0;
  logic spur = 1'b0, s_req_v, s_id_v, found;
  logic [31:0] s_req_a, s_inst, s_pc;
  vec_t tv [11];
  function automatic logic [31:0] word(input logic [31:0] a);
    return a == 32'h0 ? 32'h0010_0593 : a == 32'h4 ? 32'h0020_0613 :
           a == 32'h8 ? 32'h0030_0693 : 32'hC0DE_0000 ^ a;
  endfunction
  function automatic logic [31:0] acc(input int k);
    return k < acc_q.size() ? acc_q[k] : 32'hDEAD_BEEF;
  endfunction
  function automatic vec_t mk(input logic st, rdy, rv, input logic [31:0] rpc,
      input logic erv, input logic [31:0] era, input logic eiv, input logic [31:0] ei, ep);
    vec_t v;
    v.start = st; v.id_ready = rdy; v.redir = rv; v.redir_pc = rpc;
    v.e_req_v = erv; v.e_req_a = era; v.e_id_v = eiv; v.e_inst = ei; v.e_pc = ep;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  // one clock cycle: present due response, sample at negedge, record accepts
  task automatic cyc();
    if (q.size() > 0 && q[0].due == cyc_n) begin
      i_imem_rsp_valid = 1'b1; i_imem_rsp_data = q[0].data; void'(q.pop_front());
    end else begin
      i_imem_rsp_valid = spur; i_imem_rsp_data = spur ? 32'hBAD0_0BAD : 32'h0;
    end
    @(negedge i_clk);
    s_req_v = o_imem_req_valid; s_req_a = o_imem_req_addr;
    s_id_v = o_id_valid; s_inst = o_id_inst; s_pc = o_id_pc;
    if (o_imem_req_valid && i_imem_req_ready) begin
      q.push_back('{due: cyc_n + lat, data: word(o_imem_req_addr)});
      acc_q.push_back(o_imem_req_addr);
    end
    @(posedge i_clk); #1;
    cyc_n++;
  endtask
  task automatic do_reset();
    i_rst = 1'b1; i_start = 1'b0; i_id_ready = 1'b0; i_redirect_valid = 1'b0;
    i_imem_req_ready = 1'b1; spur = 1'b0; q.delete(); acc_q.delete();
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0; cyc_n = 0;
  endtask
  task automatic wait_id(input string name);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc();
      found = s_id_v;
    end
    chk(name, 32'(found), 32'd1);
  endtask
  initial begin
    tv[0]  = mk(1, 1, 0, 0,     0, 32'h00, 0, 32'h0, 32'h0);
    tv[1]  = mk(1, 1, 0, 0,     1, 32'h00, 0, 32'h0, 32'h0);
    tv[2]  = mk(1, 1, 0, 0,     1, 32'h04, 0, 32'h0, 32'h0);
    tv[3]  = mk(1, 1, 0, 0,     1, 32'h08, 1, 32'h0010_0593, 32'h0);
    tv[4]  = mk(1, 1, 0, 0,     1, 32'h0C, 1, 32'h0020_0613, 32'h4);
    tv[5]  = mk(1, 1, 0, 0,     1, 32'h10, 1, 32'h0030_0693, 32'h8);
    tv[6]  = mk(1, 1, 0, 0,     1, 32'h14, 1, 32'hC0DE_000C, 32'hC);
    tv[7]  = mk(1, 1, 1, 32'h42, 0, 32'h18, 1, 32'hC0DE_0010, 32'h10);
    tv[8]  = mk(1, 1, 0, 0,     1, 32'h40, 0, 32'h0, 32'h0);
    tv[9]  = mk(1, 1, 0, 0,     1, 32'h44, 0, 32'h0, 32'h0);
    tv[10] = mk(1, 1, 0, 0,     1, 32'h48, 1, 32'hC0DE_0040, 32'h40);
    do_reset();
    chk("rst_req_v", 32'(o_imem_req_valid), 32'd0);
    chk("rst_req_addr", o_imem_req_addr, 32'h0);
    chk("rst_id_v", 32'(o_id_valid), 32'd0);
    // basic stream, then a redirect coinciding with a response
    for (int i = 0; i < 11; i++) begin
      i_start = tv[i].start; i_id_ready = tv[i].id_ready;
      i_redirect_valid = tv[i].redir; i_redirect_pc = tv[i].redir_pc;
      cyc();
      chk($sformatf("t%0d_req_v", i), 32'(s_req_v), 32'(tv[i].e_req_v));
      chk($sformatf("t%0d_req_a", i), s_req_a, tv[i].e_req_a);
      chk($sformatf("t%0d_id_v", i), 32'(s_id_v), 32'(tv[i].e_id_v));
      chk($sformatf("t%0d_inst", i), s_inst, tv[i].e_inst);
      chk($sformatf("t%0d_pc", i), s_pc, tv[i].e_pc);
    end
    i_redirect_valid = 1'b0;
    // back-pressure
    do_reset(); lat = 1; i_start = 1'b1;
    repeat (10) cyc();
    chk("bp_accepts", 32'(acc_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("bp_addr%0d", k), acc(k), 32'(4 * k));
    chk("bp_req_v", 32'(s_req_v), 32'd0);
    chk("bp_inst_hold", s_inst, 32'h0010_0593);
    chk("bp_pc_hold", s_pc, 32'h0);
    i_id_ready = 1'b1; cyc();
    chk("bp_pop_req_v", 32'(s_req_v), 32'd0);
    i_id_ready = 1'b0; cyc();
    chk("bp_resume_v", 32'(s_req_v), 32'd1);
    chk("bp_resume_a", s_req_a, 32'h10);
    chk("bp_next_inst", s_inst, 32'h0020_0613);
    chk("bp_next_pc", s_pc, 32'h4);
    // redirect with two requests in flight, latency 3
    do_reset(); lat = 3; i_start = 1'b1; i_id_ready = 1'b1;
    repeat (3) cyc();
    chk("rd_inflight", 32'(acc_q.size()), 32'd2);
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h0000_0102; cyc();
    chk("rd_req_v_redir", 32'(s_req_v), 32'd0);
    i_redirect_valid = 1'b0;
    cyc(); chk("rd_flush1_req_v", 32'(s_req_v), 32'd0); chk("rd_flush1_id_v", 32'(s_id_v), 32'd0);
    cyc(); chk("rd_flush2_req_v", 32'(s_req_v), 32'd0); chk("rd_flush2_id_v", 32'(s_id_v), 32'd0);
    cyc(); chk("rd_next_v", 32'(s_req_v), 32'd1); chk("rd_next_a", s_req_a, 32'h100);
    wait_id("rd_id_seen");
    chk("rd_first_pc", s_pc, 32'h100);
    chk("rd_first_inst", s_inst, 32'hC0DE_0100);
    // redirect ignored in IDLE, address wrap, mid-run reset
    do_reset(); lat = 1; i_id_ready = 1'b1;
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h500; cyc();
    i_redirect_valid = 1'b0; i_start = 1'b1;
    repeat (3) cyc();
    chk("idle_redir_ignored", acc(0), 32'h0);
    acc_q.delete();
    i_redirect_valid = 1'b1; i_redirect_pc = 32'hFFFF_FFF9; cyc();
    i_redirect_valid = 1'b0;
    repeat (4) cyc();
    chk("wrap_a0", acc(0), 32'hFFFF_FFF8);
    chk("wrap_a1", acc(1), 32'hFFFF_FFFC);
    chk("wrap_a2", acc(2), 32'h0000_0000);
    chk("wrap_busy", 32'(o_id_valid), 32'd1);
    #3 i_rst = 1'b1;
    #1;
    chk("mrst_req_v", 32'(o_imem_req_valid), 32'd0);
    chk("mrst_req_a", o_imem_req_addr, 32'h0);
    chk("mrst_id_v", 32'(o_id_valid), 32'd0);
    chk("mrst_inst", o_id_inst, 32'h0);
    chk("mrst_pc", o_id_pc, 32'h0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    q.delete(); acc_q.delete(); cyc_n = 0; i_start = 1'b0; spur = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("spur%0d_id_v", k), 32'(s_id_v), 32'd0);
    end
    spur = 1'b0; i_start = 1'b1;
    wait_id("post_rst_id_seen");
    chk("post_rst_pc", s_pc, 32'h0);
    chk("post_rst_inst", s_inst, 32'h0010_0593);
`ifdef IF_PERF_CNT_EN
    do_reset(); lat = 2; i_start = 1'b1; i_id_ready = 1'b1;
    repeat (9) cyc();
    i_id_ready = 1'b0; cyc();
    chk("perf_fetch", o_fetch_cnt, 32'd5);
    chk("perf_stall", o_stall_cnt, 32'd3);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
